// File: rtl/btb_set_assoc_pkg.sv
// btb_set_assoc_pkg: shared types and defaults for the set-associative branch target buffer
package btb_set_assoc_pkg;
  localparam int BTB_SETS = 16;
  localparam int BTB_WAYS = 2;
  localparam int BTB_FETCH_W = 2;
  localparam int BTB_CTR_W = 2;
  typedef enum logic {BTB_IDLE, BTB_SWEEP} btb_inv_state_t;
  typedef struct packed {
    logic valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic taken;
    logic is_jal;
    logic is_br;
  } btb_upd_t;
  typedef struct packed {
    logic valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [BTB_CTR_W-1:0] ctr;
    logic is_jal;
  } btb_entry_t;
  function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction
endpackage

// File: rtl/btb_set_assoc_if.sv
// btb_set_assoc_if: fetch lookup, ROB training and invalidate signals of the BTB
interface btb_set_assoc_if #(parameter int FETCH_W = 2);
  localparam int SLOT_W = FETCH_W > 1 ? $clog2(FETCH_W) : 1;
  logic [31:0] fetch_pc;
  logic [SLOT_W-1:0] first_slot;
  logic [31:0] pred_next_pc;
  logic pred_taken;
  logic [SLOT_W-1:0] pred_slot;
  logic [FETCH_W-1:0] slot_valid;
  btb_set_assoc_pkg::btb_upd_t upd;
  logic inv_req;
  logic inv_busy;
  modport master (
    output fetch_pc, first_slot, upd, inv_req,
    input pred_next_pc, pred_taken, pred_slot, slot_valid, inv_busy
  );
  modport slave (
    input fetch_pc, first_slot, upd, inv_req,
    output pred_next_pc, pred_taken, pred_slot, slot_valid, inv_busy
  );
endinterface

// File: rtl/btb_set_assoc_sat_ctr.sv
// btb_sat_ctr: next-state of a saturating up/down counter with a force-to-max override
module btb_sat_ctr #(parameter int CTR_W = 2) (
  input logic [CTR_W-1:0] ctr,
  input logic up,
  input logic set_max,
  output logic [CTR_W-1:0] nxt
);
  always_comb nxt = set_max ? '1 : up ? (&ctr ? ctr : ctr + 1'b1) : (|ctr ? ctr - 1'b1 : ctr);
endmodule

// File: rtl/btb_set_assoc.sv
// btb_set_assoc: WAYS-way BTB predicting a FETCH_W-wide group, trained at commit, with invalidate sweep
module btb_set_assoc import btb_set_assoc_pkg::*; #(
  parameter int SETS = BTB_SETS,
  parameter int WAYS = BTB_WAYS,
  parameter int FETCH_W = BTB_FETCH_W,
  parameter int CTR_W = BTB_CTR_W
) (
  input logic clk,
  input logic rst,
  btb_set_assoc_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int SLOT_W = FETCH_W > 1 ? $clog2(FETCH_W) : 1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  logic valid [SETS][WAYS];
  logic [31:0] tag [SETS][WAYS];
  logic [31:0] target [SETS][WAYS];
  logic [CTR_W-1:0] ctr [SETS][WAYS];
  logic is_jal [SETS][WAYS];
  logic [WAY_W-1:0] rr_ptr [SETS];
  btb_inv_state_t state;
  logic [IDX_W-1:0] sweep_idx;
  logic [FETCH_W-1:0] slot_tk;
  logic [31:0] slot_tgt [FETCH_W];
  for (genvar s = 0; s < FETCH_W; s++) begin : g_slot
    logic [31:0] pc;
    logic [IDX_W-1:0] idx;
    logic hit_tk;
    logic [31:0] hit_tgt;
    assign pc = bus.fetch_pc + 32'(4 * s);
    assign idx = pc[IDX_W+1:2];
    // descending scan so the lowest matching way has the final say
    always_comb begin
      hit_tk = 1'b0;
      hit_tgt = '0;
      for (int w = WAYS - 1; w >= 0; w--)
        if (valid[idx][w] && tag[idx][w] == btb_tag(pc, IDX_W)) begin
          hit_tk = is_jal[idx][w] || ctr[idx][w][CTR_W-1];
          hit_tgt = target[idx][w];
        end
    end
    assign slot_tk[s] = hit_tk;
    assign slot_tgt[s] = hit_tgt;
  end
  logic p_tk;
  logic [SLOT_W-1:0] p_slot;
  logic [31:0] p_next;
  logic [FETCH_W-1:0] p_sv;
  always_comb begin
    p_tk = 1'b0;
    p_slot = '0;
    p_next = bus.fetch_pc + 32'(4 * FETCH_W);
    for (int s = FETCH_W - 1; s >= 0; s--)
      if (slot_tk[s] && s >= int'(bus.first_slot) && state == BTB_IDLE) begin
        p_tk = 1'b1;
        p_slot = SLOT_W'(s);
        p_next = slot_tgt[s];
      end
    for (int s = 0; s < FETCH_W; s++)
      p_sv[s] = s >= int'(bus.first_slot) && (!p_tk || s <= int'(p_slot));
  end
  assign bus.pred_taken = p_tk;
  assign bus.pred_slot = p_slot;
  assign bus.pred_next_pc = p_next;
  assign bus.slot_valid = p_sv;
  assign bus.inv_busy = state == BTB_SWEEP;
  logic [IDX_W-1:0] u_idx;
  logic [31:0] u_tag;
  logic u_en, u_jal, u_tk, u_hit, u_free;
  logic [WAY_W-1:0] u_hw, u_fw;
  logic [CTR_W-1:0] u_ctr_nxt;
  assign u_idx = bus.upd.pc[IDX_W+1:2];
  assign u_tag = btb_tag(bus.upd.pc, IDX_W);
  assign u_en = bus.upd.valid && (bus.upd.is_jal || bus.upd.is_br);
  assign u_jal = bus.upd.is_jal;
  assign u_tk = bus.upd.is_jal || bus.upd.taken;
  always_comb begin
    u_hit = 1'b0;
    u_hw = '0;
    u_free = 1'b0;
    u_fw = rr_ptr[u_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[u_idx][w] && tag[u_idx][w] == u_tag) begin
        u_hit = 1'b1;
        u_hw = WAY_W'(w);
      end
      if (!valid[u_idx][w]) begin
        u_free = 1'b1;
        u_fw = WAY_W'(w);
      end
    end
  end
  btb_sat_ctr #(.CTR_W(CTR_W)) u_sat (
    .ctr(ctr[u_idx][u_hw]),
    .up(u_tk),
    .set_max(u_jal),
    .nxt(u_ctr_nxt)
  );
  // tags, targets and is_jal are qualified by valid, so reset leaves them alone
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BTB_IDLE;
      sweep_idx <= '0;
      for (int i = 0; i < SETS; i++) begin
        rr_ptr[i] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid[i][w] <= 1'b0;
          ctr[i][w] <= '0;
        end
      end
    end else if (state == BTB_SWEEP) begin
      for (int w = 0; w < WAYS; w++) valid[sweep_idx][w] <= 1'b0;
      sweep_idx <= sweep_idx + 1'b1;
      if (sweep_idx == IDX_W'(SETS - 1)) state <= BTB_IDLE;
    end else if (bus.inv_req) begin
      state <= BTB_SWEEP;
      sweep_idx <= '0;
    end else if (u_en && u_hit) begin
      ctr[u_idx][u_hw] <= u_ctr_nxt;
      is_jal[u_idx][u_hw] <= u_jal;
      if (u_tk) target[u_idx][u_hw] <= bus.upd.target;
    end else if (u_en && u_tk) begin
      valid[u_idx][u_fw] <= 1'b1;
      tag[u_idx][u_fw] <= u_tag;
      target[u_idx][u_fw] <= bus.upd.target;
      ctr[u_idx][u_fw] <= u_jal ? '1 : CTR_WEAK;
      is_jal[u_idx][u_fw] <= u_jal;
      if (!u_free) rr_ptr[u_idx] <= WAY_W'((int'(rr_ptr[u_idx]) + 1) % WAYS);
    end
  end
endmodule

// File: tb/tb_btb_set_assoc.sv
// tb_btb_set_assoc: directed vector table plus invalidate and reset-abort sequences
module tb_btb_set_assoc;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  btb_set_assoc_if #(.FETCH_W(2)) bus ();
  btb_set_assoc dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    bit is_upd;
    logic [31:0] pc;
    logic [31:0] tgt;
    bit tk, jal, br;
    logic fs;
    bit e_tk;
    logic e_slot;
    logic [31:0] e_next;
    logic [1:0] e_sv;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk_u(logic [31:0] pc, logic [31:0] tgt, bit tk, bit jal, bit br);
    vec_t v = '{is_upd: 1'b1, pc: pc, tgt: tgt, tk: tk, jal: jal, br: br, fs: 1'b0,
                e_tk: 1'b0, e_slot: 1'b0, e_next: 32'h0, e_sv: 2'b00};
    return v;
  endfunction
  function automatic vec_t mk_l(logic [31:0] pc, logic fs, bit e_tk, logic e_slot, logic [31:0] e_next, logic [1:0] e_sv);
    vec_t v = '{is_upd: 1'b0, pc: pc, tgt: 32'h0, tk: 1'b0, jal: 1'b0, br: 1'b0, fs: fs,
                e_tk: e_tk, e_slot: e_slot, e_next: e_next, e_sv: e_sv};
    return v;
  endfunction
  task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit jal, input bit br);
    @(negedge clk);
    bus.upd = '{valid: 1'b1, pc: pc, target: tgt, taken: tk, is_jal: jal, is_br: br};
    @(negedge clk);
    bus.upd.valid = 1'b0;
  endtask
  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic look(input string name, input logic [31:0] pc, input logic fs, input bit e_tk,
                      input logic e_slot, input logic [31:0] e_next, input logic [1:0] e_sv);
    @(negedge clk);
    bus.fetch_pc = pc;
    bus.first_slot = fs;
    #1;
    total++;
    if ({bus.pred_taken, bus.pred_slot, bus.pred_next_pc, bus.slot_valid} !== {e_tk, e_slot, e_next, e_sv}) begin
      bad++;
      $display("FAIL %s pc=%h fs=%0d: got tk=%0b slot=%0d next=%h sv=%b expected tk=%0b slot=%0d next=%h sv=%b",
               name, pc, fs, bus.pred_taken, bus.pred_slot, bus.pred_next_pc, bus.slot_valid,
               e_tk, e_slot, e_next, e_sv);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    rst = 1'b1;
    bus.upd = '0;
    bus.inv_req = 1'b0;
    bus.fetch_pc = 32'h100;
    bus.first_slot = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vecs.push_back(mk_l(32'h100, 0, 0, 0, 32'h108, 2'b11));
    vecs.push_back(mk_u(32'h104, 32'h200, 1, 0, 1));
    vecs.push_back(mk_l(32'h100, 0, 1, 1, 32'h200, 2'b11));
    vecs.push_back(mk_l(32'h100, 1, 1, 1, 32'h200, 2'b10));
    vecs.push_back(mk_u(32'h104, 32'h200, 0, 0, 1));
    vecs.push_back(mk_l(32'h100, 0, 0, 0, 32'h108, 2'b11));
    vecs.push_back(mk_u(32'h104, 32'h200, 0, 0, 1));
    vecs.push_back(mk_u(32'h104, 32'h200, 1, 0, 1));
    vecs.push_back(mk_l(32'h100, 0, 0, 0, 32'h108, 2'b11));
    vecs.push_back(mk_u(32'h1000, 32'hA000, 1, 0, 1));
    vecs.push_back(mk_u(32'h2000, 32'hB000, 1, 0, 1));
    vecs.push_back(mk_u(32'h3000, 32'hC000, 1, 1, 0));
    vecs.push_back(mk_l(32'h1000, 0, 0, 0, 32'h1008, 2'b11));
    vecs.push_back(mk_l(32'h2000, 0, 1, 0, 32'hB000, 2'b01));
    vecs.push_back(mk_l(32'h3000, 0, 1, 0, 32'hC000, 2'b01));
    vecs.push_back(mk_u(32'h104, 32'h200, 1, 0, 1));
    vecs.push_back(mk_u(32'h100, 32'h400, 1, 1, 1));
    vecs.push_back(mk_l(32'h100, 0, 1, 0, 32'h400, 2'b01));
    vecs.push_back(mk_l(32'h100, 1, 1, 1, 32'h200, 2'b10));
    vecs.push_back(mk_l(32'h2000, 0, 0, 0, 32'h2008, 2'b11));
    vecs.push_back(mk_l(32'hFFFF_FFF8, 0, 0, 0, 32'h0, 2'b11));
    vecs.push_back(mk_u(32'h104, 32'h240, 1, 0, 1));
    vecs.push_back(mk_l(32'h100, 1, 1, 1, 32'h240, 2'b10));
    vecs.push_back(mk_u(32'h700, 32'h900, 0, 0, 1));
    vecs.push_back(mk_l(32'h700, 0, 0, 0, 32'h708, 2'b11));
    vecs.push_back(mk_l(32'h3000, 0, 1, 0, 32'hC000, 2'b01));
    cmp("reset_inv_busy", 64'(bus.inv_busy), 64'd0);
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].is_upd) do_upd(vecs[i].pc, vecs[i].tgt, vecs[i].tk, vecs[i].jal, vecs[i].br);
      else look($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fs, vecs[i].e_tk, vecs[i].e_slot, vecs[i].e_next, vecs[i].e_sv);
    // invalidate collides with an update; a second update arrives mid-sweep
    @(negedge clk);
    bus.inv_req = 1'b1;
    bus.upd = '{valid: 1'b1, pc: 32'h500, target: 32'h900, taken: 1'b1, is_jal: 1'b1, is_br: 1'b0};
    @(negedge clk);
    bus.inv_req = 1'b0;
    bus.upd = '{valid: 1'b1, pc: 32'h600, target: 32'h980, taken: 1'b1, is_jal: 1'b1, is_br: 1'b0};
    bus.fetch_pc = 32'h100;
    bus.first_slot = 1'b0;
    #1;
    cmp("sweep_forces_not_taken", 64'(bus.pred_taken), 64'd0);
    cmp("sweep_busy_first", 64'(bus.inv_busy), 64'd1);
    n = 0;
    while (bus.inv_busy && n < 40) begin
      n++;
      @(negedge clk);
      bus.upd.valid = 1'b0;
      #1;
    end
    cmp("sweep_cycles", 64'(n), 64'd16);
    look("post_inv_100", 32'h100, 0, 0, 0, 32'h108, 2'b11);
    look("post_inv_3000", 32'h3000, 0, 0, 0, 32'h3008, 2'b11);
    look("post_inv_500", 32'h500, 0, 0, 0, 32'h508, 2'b11);
    look("post_inv_600", 32'h600, 0, 0, 0, 32'h608, 2'b11);
    // reset in the middle of a sweep returns to idle and accepts training
    do_upd(32'h100, 32'h400, 1, 1, 0);
    look("pre_abort_hit", 32'h100, 0, 1, 0, 32'h400, 2'b01);
    @(negedge clk);
    bus.inv_req = 1'b1;
    @(negedge clk);
    bus.inv_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("abort_inv_busy", 64'(bus.inv_busy), 64'd0);
    look("abort_miss", 32'h100, 0, 0, 0, 32'h108, 2'b11);
    do_upd(32'h100, 32'h400, 1, 1, 0);
    look("abort_retrain", 32'h100, 0, 1, 0, 32'h400, 2'b01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
